// File: rtl/execute_alu_arb.sv
// execute_alu_arb: round-robin arbiter between two requesters for the shared
// execute-stage ALU, with a one-entry registered response and valid/ready flow control.
module execute_alu_arb #(
  parameter int unsigned DW = 32,
  parameter int unsigned TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          req0_vld,
  output logic          req0_rdy,
  input  logic [6:0]    req0_opcode,
  input  logic [2:0]    req0_funct3,
  input  logic          req0_funct7,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [TW-1:0] req0_tag,
  input  logic          req1_vld,
  output logic          req1_rdy,
  input  logic [6:0]    req1_opcode,
  input  logic [2:0]    req1_funct3,
  input  logic          req1_funct7,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [TW-1:0] req1_tag,
  output logic [6:0]    alu_opcode,
  output logic [2:0]    alu_funct3,
  output logic          alu_funct7,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_y,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [DW-1:0] rsp_y,
  output logic          rsp_src,
  output logic [TW-1:0] rsp_tag
);

  // lp_q = index of the last winner; lp_q = 1 means requester 0 wins the next tie.
  logic          lp_q, lp_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [DW-1:0] rsp_y_q, rsp_y_d;
  logic          rsp_src_q, rsp_src_d;
  logic [TW-1:0] rsp_tag_q, rsp_tag_d;

  logic avail;
  logic gnt0, gnt1;

  // Grant decision; no grant while reset is held so nothing is accepted and lost.
  always_comb begin
    avail = !rst && !flush && (!rsp_vld_q || rsp_rdy);
    gnt0  = avail && req0_vld && (!req1_vld || lp_q);
    gnt1  = avail && req1_vld && (!req0_vld || !lp_q);
  end

  assign req0_rdy = gnt0;
  assign req1_rdy = gnt1;

  // Route the granted request onto the ALU; all-zero when idle.
  always_comb begin
    alu_opcode = '0;
    alu_funct3 = '0;
    alu_funct7 = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    if (gnt0) begin
      alu_opcode = req0_opcode;
      alu_funct3 = req0_funct3;
      alu_funct7 = req0_funct7;
      alu_a      = req0_a;
      alu_b      = req0_b;
    end else if (gnt1) begin
      alu_opcode = req1_opcode;
      alu_funct3 = req1_funct3;
      alu_funct7 = req1_funct7;
      alu_a      = req1_a;
      alu_b      = req1_b;
    end
  end

  // Response register and round-robin pointer next-state.
  always_comb begin
    lp_d      = lp_q;
    rsp_vld_d = rsp_vld_q;
    rsp_y_d   = rsp_y_q;
    rsp_src_d = rsp_src_q;
    rsp_tag_d = rsp_tag_q;
    if (gnt0 || gnt1) begin
      rsp_vld_d = 1'b1;
      rsp_y_d   = alu_y;
      rsp_src_d = gnt1;
      rsp_tag_d = gnt1 ? req1_tag : req0_tag;
      lp_d      = gnt1;
    end else if (rsp_rdy || flush) begin
      rsp_vld_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lp_q      <= 1'b1;
      rsp_vld_q <= 1'b0;
      rsp_y_q   <= '0;
      rsp_src_q <= 1'b0;
      rsp_tag_q <= '0;
    end else begin
      lp_q      <= lp_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_y_q   <= rsp_y_d;
      rsp_src_q <= rsp_src_d;
      rsp_tag_q <= rsp_tag_d;
    end
  end

  assign rsp_vld = rsp_vld_q;
  assign rsp_y   = rsp_y_q;
  assign rsp_src = rsp_src_q;
  assign rsp_tag = rsp_tag_q;

endmodule
